// File: rtl/qed_fifo_target.sv
// qed_fifo_target: single-clock FIFO used as the DUT for the A-QED FIFO checker.
// One-cycle registered read latency, same-cycle bypass when empty, flush,
// clock-enable stall and sticky overflow/underflow flags.
module qed_fifo_target #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 32,
  parameter int AF_LEVEL = 28,
  parameter int AE_LEVEL = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clk_en,
  input  logic                     flush,
  input  logic                     wen,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     ren,
  output logic [WIDTH-1:0]         data_out,
  output logic                     valid_out,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   num_words,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
  logic [CW-1:0]    num_next;
  logic             active, do_rd, do_wr, bypass, mem_wr, mem_rd;
  logic             drop_wr, drop_rd;

  // Accept terms and next-state for pointers and occupancy.
  // Bypass is a read+write pair that never touches memory, so it is
  // excluded from the pointer/count updates to keep occupancy net zero.
  always_comb begin
    active      = clk_en & ~flush;
    do_rd       = active & ren & (~empty | wen);
    do_wr       = active & wen & (~full | do_rd);
    bypass      = do_rd & empty;
    mem_wr      = do_wr & ~bypass;
    mem_rd      = do_rd & ~bypass;
    drop_wr     = active & wen & full & ~do_rd;
    drop_rd     = active & ren & empty & ~wen;
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    num_next    = num_words;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      num_next    = '0;
    end else if (clk_en) begin
      if (mem_wr) wr_ptr_next = wr_ptr + 1'b1;
      if (mem_rd) rd_ptr_next = rd_ptr + 1'b1;
      num_next = num_words + CW'(mem_wr) - CW'(mem_rd);
    end
  end

  // Storage array; no reset needed since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (!reset && mem_wr) mem[wr_ptr] <= data_in;
  end

  // Pointers, occupancy and registered status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      num_words    <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      wr_ptr       <= wr_ptr_next;
      rd_ptr       <= rd_ptr_next;
      num_words    <= num_next;
      empty        <= (num_next == '0);
      full         <= (num_next == CW'(DEPTH));
      almost_full  <= (num_next >= CW'(AF_LEVEL));
      almost_empty <= (num_next <= CW'(AE_LEVEL));
    end
  end

  // Read data path: data_out holds unless a read or bypass is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out  <= '0;
      valid_out <= 1'b0;
    end else if (flush) begin
      valid_out <= 1'b0;
    end else if (clk_en) begin
      valid_out <= do_rd;
      if (do_rd) data_out <= bypass ? data_in : mem[rd_ptr];
    end
  end

  // Sticky protocol-error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (drop_wr) overflow  <= 1'b1;
      if (drop_rd) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_qed_fifo_target.sv
// Directed testbench for qed_fifo_target (default parameters: 16 x 32).
module tb_qed_fifo_target;

  logic        clk = 1'b0;
  logic        reset, clk_en, flush, wen, ren;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        valid_out, empty, full, almost_full, almost_empty;
  logic [5:0]  num_words;
  logic        overflow, underflow;

  int pass_cnt  = 0;
  int total_cnt = 0;

  qed_fifo_target #(.WIDTH(16), .DEPTH(32), .AF_LEVEL(28), .AE_LEVEL(4)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .flush(flush), .wen(wen),
    .data_in(data_in), .ren(ren), .data_out(data_out), .valid_out(valid_out),
    .empty(empty), .full(full), .almost_full(almost_full),
    .almost_empty(almost_empty), .num_words(num_words),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen = 1'b0; ren = 1'b0; flush = 1'b0; clk_en = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    data_in = 16'h0;
    do_reset();
    total_cnt++;
    if ({data_out, valid_out, empty, full, almost_full, almost_empty, num_words, overflow, underflow}
        !== {16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 6'd0, 1'b0, 1'b0})
      $display("FAIL reset_state: dout=%h v=%b e=%b f=%b af=%b ae=%b n=%0d ov=%b un=%b, required 0000 0 1 0 0 1 0 0 0",
               data_out, valid_out, empty, full, almost_full, almost_empty, num_words, overflow, underflow);
    else pass_cnt++;
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int i = 1; i <= 32; i++) begin
      wen = 1'b1; data_in = 16'(i);
      step();
      total_cnt++;
      if ({num_words, almost_full, almost_empty, full, empty}
          !== {6'(i), (i >= 28), (i <= 4), (i == 32), 1'b0})
        $display("FAIL fill_%0d: n=%0d af=%b ae=%b f=%b e=%b, required n=%0d af=%b ae=%b f=%b e=0",
                 i, num_words, almost_full, almost_empty, full, empty, i, i >= 28, i <= 4, i == 32);
      else pass_cnt++;
    end
    wen = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      ren = 1'b1;
      step();
      total_cnt++;
      if ({valid_out, data_out, num_words} !== {1'b1, 16'(i), 6'(32 - i)})
        $display("FAIL drain_%0d: v=%b dout=%h n=%0d, required v=1 dout=%h n=%0d",
                 i, valid_out, data_out, num_words, 16'(i), 32 - i);
      else pass_cnt++;
    end
    ren = 1'b0;
    step();
    total_cnt++;
    if ({valid_out, empty, full, overflow, underflow} !== 5'b01000)
      $display("FAIL drain_end: v=%b e=%b f=%b ov=%b un=%b, required 0 1 0 0 0",
               valid_out, empty, full, overflow, underflow);
    else pass_cnt++;
  endtask

  task automatic test_full_rw();
    do_reset();
    for (int i = 0; i < 32; i++) begin
      wen = 1'b1; data_in = 16'h0100 + 16'(i);
      step();
    end
    wen = 1'b1; ren = 1'b1; data_in = 16'h1234;
    step();
    total_cnt++;
    if ({valid_out, data_out, num_words, full, overflow} !== {1'b1, 16'h0100, 6'd32, 1'b1, 1'b0})
      $display("FAIL full_rw: v=%b dout=%h n=%0d f=%b ov=%b, required 1 0100 32 1 0",
               valid_out, data_out, num_words, full, overflow);
    else pass_cnt++;
    ren = 1'b0; data_in = 16'h5555;
    step();
    total_cnt++;
    if ({valid_out, num_words, overflow} !== {1'b0, 6'd32, 1'b1})
      $display("FAIL full_drop: v=%b n=%0d ov=%b, required 0 32 1", valid_out, num_words, overflow);
    else pass_cnt++;
    wen = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      ren = 1'b1;
      step();
      total_cnt++;
      if ({valid_out, data_out} !== {1'b1, (i == 32) ? 16'h1234 : 16'h0100 + 16'(i)})
        $display("FAIL full_order_%0d: v=%b dout=%h, required v=1 dout=%h",
                 i, valid_out, data_out, (i == 32) ? 16'h1234 : 16'h0100 + 16'(i));
      else pass_cnt++;
    end
    ren = 1'b0;
    step();
    total_cnt++;
    if ({empty, num_words, underflow} !== {1'b1, 6'd0, 1'b0})
      $display("FAIL full_end: e=%b n=%0d un=%b, required 1 0 0", empty, num_words, underflow);
    else pass_cnt++;
  endtask

  task automatic test_bypass();
    do_reset();
    wen = 1'b1; ren = 1'b1; data_in = 16'hBEEF;
    step();
    total_cnt++;
    if ({valid_out, data_out, num_words, empty, underflow} !== {1'b1, 16'hBEEF, 6'd0, 1'b1, 1'b0})
      $display("FAIL bypass: v=%b dout=%h n=%0d e=%b un=%b, required 1 beef 0 1 0",
               valid_out, data_out, num_words, empty, underflow);
    else pass_cnt++;
    idle();
    step();
    total_cnt++;
    if ({valid_out, data_out} !== {1'b0, 16'hBEEF})
      $display("FAIL bypass_after: v=%b dout=%h, required 0 beef", valid_out, data_out);
    else pass_cnt++;
  endtask

  task automatic test_underflow_flush();
    // Continues from the bypass state: data_out = BEEF, empty.
    ren = 1'b1;
    step();
    total_cnt++;
    if ({valid_out, underflow, data_out} !== {1'b0, 1'b1, 16'hBEEF})
      $display("FAIL underflow: v=%b un=%b dout=%h, required 0 1 beef", valid_out, underflow, data_out);
    else pass_cnt++;
    ren = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wen = 1'b1; data_in = 16'h0C00 + 16'(i);
      step();
    end
    total_cnt++;
    if (num_words !== 6'd5)
      $display("FAIL preflush_count: n=%0d, required 5", num_words);
    else pass_cnt++;
    flush = 1'b1; wen = 1'b1; data_in = 16'hDEAD;
    step();
    total_cnt++;
    if ({num_words, empty, underflow, valid_out, data_out} !== {6'd0, 1'b1, 1'b1, 1'b0, 16'hBEEF})
      $display("FAIL flush: n=%0d e=%b un=%b v=%b dout=%h, required 0 1 1 0 beef",
               num_words, empty, underflow, valid_out, data_out);
    else pass_cnt++;
    flush = 1'b0; wen = 1'b1; data_in = 16'h7777;
    step();
    wen = 1'b0; ren = 1'b1;
    step();
    ren = 1'b0;
    total_cnt++;
    if ({valid_out, data_out, empty} !== {1'b1, 16'h7777, 1'b1})
      $display("FAIL post_flush_read: v=%b dout=%h e=%b, required 1 7777 1", valid_out, data_out, empty);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      wen = 1'b1; data_in = 16'h0A00 + 16'(i);
      step();
    end
    wen = 1'b0; ren = 1'b1; clk_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      total_cnt++;
      if ({num_words, valid_out, data_out} !== {6'd3, 1'b0, 16'h0000})
        $display("FAIL stall_%0d: n=%0d v=%b dout=%h, required 3 0 0000", i, num_words, valid_out, data_out);
      else pass_cnt++;
    end
    clk_en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      total_cnt++;
      if ({valid_out, data_out, num_words} !== {1'b1, 16'h0A00 + 16'(i), 6'(3 - i)})
        $display("FAIL stall_resume_%0d: v=%b dout=%h n=%0d, required 1 %h %0d",
                 i, valid_out, data_out, num_words, 16'h0A00 + 16'(i), 3 - i);
      else pass_cnt++;
    end
    ren = 1'b0;
  endtask

  task automatic test_aqed_pair();
    logic [15:0] vals [16];
    int widx = 0, ridx = 0, outstanding = 0, cyc = 0;
    logic w, r;
    for (int i = 0; i < 16; i++) vals[i] = (i == 7 || i == 12) ? 16'h00AA : 16'h1000 + 16'(i);
    do_reset();
    while (ridx < 16 && cyc < 200) begin
      w = (widx < 16) && (cyc % 3 != 2);
      r = ((cyc % 2) == 1 || widx >= 16) && (outstanding > 0 || w);
      wen = w; ren = r; data_in = w ? vals[widx] : 16'h0;
      step();
      if (w) begin widx++; outstanding++; end
      if (r) outstanding--;
      if (valid_out) begin
        total_cnt++;
        if (data_out !== vals[ridx])
          $display("FAIL aqed_out_%0d: dout=%h, required %h", ridx, data_out, vals[ridx]);
        else pass_cnt++;
        ridx++;
      end
      cyc++;
    end
    idle();
    total_cnt++;
    if (ridx != 16)
      $display("FAIL aqed_timeout: outputs=%0d, required 16", ridx);
    else pass_cnt++;
  endtask

  task automatic test_reset_midflight();
    do_reset();
    wen = 1'b1; data_in = 16'h0E01;
    step();
    data_in = 16'h0E02;
    step();
    wen = 1'b0; ren = 1'b1; reset = 1'b1;
    step();
    reset = 1'b0; ren = 1'b0;
    total_cnt++;
    if ({valid_out, num_words, empty, data_out} !== {1'b0, 6'd0, 1'b1, 16'h0000})
      $display("FAIL reset_midflight: v=%b n=%0d e=%b dout=%h, required 0 0 1 0000",
               valid_out, num_words, empty, data_out);
    else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1; clk_en = 1'b1; flush = 1'b0; wen = 1'b0; ren = 1'b0; data_in = '0;
    test_reset();
    test_fill_drain();
    test_full_rw();
    test_bypass();
    test_underflow_flush();
    test_stall();
    test_aqed_pair();
    test_reset_midflight();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
